// File: rtl/simplecore_pkg.sv
// rtl/simplecore_pkg.sv - shared SimpleCore instruction-port types and constants
package simplecore_pkg;

  localparam int INST_W = 16;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;
  localparam logic [INST_W-1:0] ERR_INST = 16'hFFFF;

  typedef enum logic [1:0] {
    IM_IDLE  = 2'd0,
    IM_RD_HI = 2'd1,
    IM_RD_LO = 2'd2,
    IM_ERR   = 2'd3
  } im_state_e;

endpackage

// File: rtl/imem_wait_timer.sv
// rtl/imem_wait_timer.sv - saturating 8-bit wait-state counter with terminal-count flag
module imem_wait_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic nReset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tc marks the last allowed wait cycle of the current strobe
  assign tc = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/imem_port.sv
// rtl/imem_port.sv - 16-bit instruction fetch responder over an 8-bit wait-state memory
module imem_port #(
  parameter int          AW       = 15,
  parameter int          TIMEOUT  = 8,
  parameter logic [15:0] NOP_INST = simplecore_pkg::NOP_INST,
  parameter logic [15:0] ERR_INST = simplecore_pkg::ERR_INST
) (
  input  logic                              clk,
  input  logic                              nReset,
  input  logic                              fReq,
  input  logic [AW-1:0]                     fAddr,
  output logic [simplecore_pkg::INST_W-1:0] dOut,
  output logic                              dValid,
  output logic                              fBusy,
  output logic                              fErr,
  output logic [AW:0]                       mAddr,
  output logic                              mRd,
  input  logic                              mRdy,
  input  logic [7:0]                        mData
);

  import simplecore_pkg::*;

  im_state_e         state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        hi_q, hi_d;
  logic [INST_W-1:0] dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              ferr_q, ferr_d;
  logic              fbusy_q, fbusy_d;
  logic [AW:0]       maddr_q, maddr_d;
  logic              mrd_q, mrd_d;
  logic              tmr_en;
  logic              tmr_tc;

  assign tmr_en = ((state_q == IM_RD_HI) || (state_q == IM_RD_LO)) && !mRdy;

  imem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .nReset (nReset),
    .clr    (!tmr_en),
    .en     (tmr_en),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ferr_d   = 1'b0;
    fbusy_d  = fbusy_q;
    maddr_d  = maddr_q;
    mrd_d    = mrd_q;
    case (state_q)
      IM_IDLE: begin
        if (fReq) begin
          addr_d  = fAddr;
          maddr_d = {fAddr, 1'b0};
          mrd_d   = 1'b1;
          fbusy_d = 1'b1;
          state_d = IM_RD_HI;
        end
      end
      IM_RD_HI: begin
        if (mRdy) begin
          hi_d    = mData;
          maddr_d = {addr_q, 1'b1};
          state_d = IM_RD_LO;
        end else if (tmr_tc) begin
          mrd_d   = 1'b0;
          state_d = IM_ERR;
        end
      end
      IM_RD_LO: begin
        if (mRdy) begin
          dout_d   = {hi_q, mData};
          dvalid_d = 1'b1;
          mrd_d    = 1'b0;
          fbusy_d  = 1'b0;
          state_d  = IM_IDLE;
        end else if (tmr_tc) begin
          mrd_d   = 1'b0;
          state_d = IM_ERR;
        end
      end
      IM_ERR: begin
        // strobe already dropped on entry; report the abort to the core
        dout_d   = ERR_INST;
        dvalid_d = 1'b1;
        ferr_d   = 1'b1;
        fbusy_d  = 1'b0;
        state_d  = IM_IDLE;
      end
      default: state_d = IM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IM_IDLE;
      addr_q   <= '0;
      hi_q     <= 8'd0;
      dout_q   <= NOP_INST;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      fbusy_q  <= 1'b0;
      maddr_q  <= '0;
      mrd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
      fbusy_q  <= fbusy_d;
      maddr_q  <= maddr_d;
      mrd_q    <= mrd_d;
    end
  end

  assign dOut   = dout_q;
  assign dValid = dvalid_q;
  assign fErr   = ferr_q;
  assign fBusy  = fbusy_q;
  assign mAddr  = maddr_q;
  assign mRd    = mrd_q;

endmodule

// File: tb/tb_imem_port.sv
// tb/tb_imem_port.sv - scoreboard bench for imem_port with a wait-state memory responder
module tb_imem_port;

  logic        clk = 1'b0;
  logic        nReset;
  logic        fReq;
  logic [14:0] fAddr;
  logic [15:0] dOut;
  logic        dValid;
  logic        fBusy;
  logic        fErr;
  logic [15:0] mAddr;
  logic        mRd;
  logic        mRdy;
  logic [7:0]  mData;

  imem_port dut (
    .clk    (clk),
    .nReset (nReset),
    .fReq   (fReq),
    .fAddr  (fAddr),
    .dOut   (dOut),
    .dValid (dValid),
    .fBusy  (fBusy),
    .fErr   (fErr),
    .mAddr  (mAddr),
    .mRd    (mRd),
    .mRdy   (mRdy),
    .mData  (mData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          accept_q[$];
  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_delay = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: mRdy after mem_delay stall cycles of each strobe
  logic        prev_rd = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  int          stall = 0;

  always @(negedge clk) begin
    if (!nReset) begin
      mRdy  = 1'b0;
      mData = 8'hEE;
      stall = 0;
    end else if (mRd) begin
      if (prev_rd && !prev_rdy) chk("maddr_stable", {16'h0, mAddr}, {16'h0, prev_addr});
      if (!prev_rd || prev_rdy) stall = 0;
      else stall++;
      mRdy = (stall >= mem_delay);
      if (mRdy) begin
        mData = mem[mAddr];
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL maddr_unexpected actual=%h required=none", mAddr);
        end else begin
          chk("maddr", {16'h0, mAddr}, {16'h0, addr_q.pop_front()});
        end
      end else begin
        mData = 8'hEE;
      end
    end else begin
      mRdy  = 1'b0;
      mData = 8'hEE;
    end
    prev_rd   = mRd;
    prev_rdy  = mRdy;
    prev_addr = mAddr;
  end

  // Response monitor
  logic        prev_busy = 1'b0;
  logic        prev_dv = 1'b0;
  logic [15:0] last_dout = 16'h0;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!nReset) begin
      accept_q.delete();
      last_dout = dOut;
      prev_busy = 1'b0;
      prev_dv   = 1'b0;
    end else begin
      if (dValid) begin
        chk("dvalid_back_to_back", {31'h0, prev_dv}, 32'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dvalid_unexpected actual=%h required=none", dOut);
        end else begin
          e = exp_q.pop_front();
          a = (accept_q.size() != 0) ? accept_q.pop_front() : -1000;
          chk("dout", {16'h0, dOut}, {16'h0, e.d});
          chk("ferr", {31'h0, fErr}, {31'h0, e.e});
          chk("latency", cyc - a, e.lat);
          chk("fbusy_at_dvalid", {31'h0, fBusy}, 32'h0);
          chk("mrd_at_dvalid", {31'h0, mRd}, 32'h0);
        end
        last_dout = dOut;
      end else begin
        chk("dout_hold", {16'h0, dOut}, {16'h0, last_dout});
        chk("ferr_without_dvalid", {31'h0, fErr}, 32'h0);
      end
      if (fBusy && !prev_busy) accept_q.push_back(cyc);
      prev_busy = fBusy;
      prev_dv   = dValid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (fBusy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_bound", {31'h0, fBusy}, 32'h0);
  endtask

  task automatic fetch(input logic [14:0] a, input int dly, input logic [15:0] d,
                       input logic e, input int lat);
    wait_idle();
    mem_delay = dly;
    exp_q.push_back('{d, e, lat});
    if (!e) begin
      addr_q.push_back({a, 1'b0});
      addr_q.push_back({a, 1'b1});
    end
    fAddr = a;
    fReq  = 1'b1;
    @(negedge clk);
    fReq  = 1'b0;
    fAddr = ~a;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"},   {16'h0, dOut}, 32'h0000);
    chk({tag, "_dvalid"}, {31'h0, dValid}, 32'h0);
    chk({tag, "_fbusy"},  {31'h0, fBusy}, 32'h0);
    chk({tag, "_ferr"},   {31'h0, fErr}, 32'h0);
    chk({tag, "_mrd"},    {31'h0, mRd}, 32'h0);
    chk({tag, "_maddr"},  {16'h0, mAddr}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nReset = 1'b0;
    fReq   = 1'b0;
    fAddr  = 15'h0;
    mRdy   = 1'b0;
    mData  = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
    mem[16'h0002] = 8'h33; mem[16'h0003] = 8'h44;
    mem[16'h0024] = 8'hA5; mem[16'h0025] = 8'h3C;
    mem[16'h0080] = 8'h5A; mem[16'h0081] = 8'hC3;
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h34;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    fetch(15'h0012, 0,   16'hA53C, 1'b0, 2);
    fetch(15'h0040, 3,   16'h5AC3, 1'b0, 8);
    fetch(15'h0005, 255, 16'hFFFF, 1'b1, 9);
    fetch(15'h0012, 0,   16'hA53C, 1'b0, 2);

    // back-to-back with fReq held high; fAddr changed while busy
    wait_idle();
    mem_delay = 0;
    exp_q.push_back('{16'h1122, 1'b0, 2});
    exp_q.push_back('{16'h3344, 1'b0, 2});
    for (int i = 0; i < 4; i++) addr_q.push_back(16'(i));
    fAddr = 15'h0000;
    fReq  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!fBusy && n < 20);
    fAddr = 15'h0001;
    n = 0;
    while (fBusy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!fBusy && n < 20) begin @(negedge clk); n++; end
    chk("b2b_second_accept", {31'h0, fBusy}, 32'h1);
    fReq = 1'b0;

    fetch(15'h7FFF, 0, 16'h1234, 1'b0, 2);

    // reset while waiting for the low byte
    wait_idle();
    mem_delay = 3;
    addr_q.push_back(16'h0024);
    fAddr = 15'h0012;
    fReq  = 1'b1;
    @(negedge clk);
    fReq = 1'b0;
    n = 0;
    while (!(mRd && mAddr[0]) && n < 50) begin @(negedge clk); n++; end
    chk("reach_rd_lo", {31'h0, mRd && mAddr[0]}, 32'h1);
    #3 nReset = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    fetch(15'h0001, 0, 16'h3344, 1'b0, 2);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("addr_queue_empty", addr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
